// File: rtl/cordic16_serial_if.sv
// Operand/result bundle for the serial CORDIC engine: the master drives operands
// and load, the slave (engine) returns results and the rdy strobe.
interface cordic16_serial_if;
  logic signed [15:0] xi, yi, zi;
  logic               load, mi;
  logic signed [15:0] xo, yo, zo;
  logic               mo, rdy;

  modport master (output xi, yi, zi, load, mi, input  xo, yo, zo, mo, rdy);
  modport slave  (input  xi, yi, zi, load, mi, output xo, yo, zo, mo, rdy);
endinterface

// File: rtl/cordic16_serial.sv
// Iterative 16-bit CORDIC (rotation / vectoring) with quadrant pre-rotation,
// shift-add gain compensation and a fixed FRAME-clock load-to-result latency.
module cordic16_serial #(
  parameter int ITER  = 16,
  parameter int FRAME = 40
) (
  input  logic             clk,
  input  logic             rst,
  cordic16_serial_if.slave io
);
  localparam int W = 26;  // 18 integer bits (2 guard MSBs) + 8 fraction bits
  localparam int F = 8;
  localparam int NGAIN = 7;
  localparam logic [5:0] LAST = 6'(FRAME - 2);
  localparam logic signed [23:0]  Q90   = 24'sh400000;
  localparam logic signed [W-1:0] SMAX  = W'(32767);
  localparam logic signed [W-1:0] SMIN  = W'(-32768);
  localparam logic signed [W-1:0] RHALF = W'(1 << (F - 1));

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ROT, S_GAIN, S_HOLD} state_t;

  state_t              state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [4:0]          it_q, it_d;
  logic signed [W-1:0] x_q, x_d, y_q, y_d, ax_q, ax_d, ay_q, ay_d;
  logic signed [23:0]  z_q, z_d;
  logic                mode_q, mode_d, zvec_q, zvec_d;
  logic signed [15:0]  xo_q, xo_d, yo_q, yo_d, zo_q, zo_d;
  logic                mo_q, mo_d, rdy_q, rdy_d;

  logic                ccw;
  logic signed [W-1:0] xs, ys, gx, gy;
  logic signed [23:0]  at;
  logic [5:0]          gt;

  // atan(2^-i), 2^24 = one full turn, rounded
  function automatic logic signed [23:0] atan_rom(input logic [4:0] i);
    case (i)
      5'd0:    atan_rom = 24'sd2097152;
      5'd1:    atan_rom = 24'sd1238021;
      5'd2:    atan_rom = 24'sd654136;
      5'd3:    atan_rom = 24'sd332050;
      5'd4:    atan_rom = 24'sd166669;
      5'd5:    atan_rom = 24'sd83416;
      5'd6:    atan_rom = 24'sd41718;
      5'd7:    atan_rom = 24'sd20860;
      5'd8:    atan_rom = 24'sd10430;
      5'd9:    atan_rom = 24'sd5215;
      5'd10:   atan_rom = 24'sd2608;
      5'd11:   atan_rom = 24'sd1304;
      5'd12:   atan_rom = 24'sd652;
      5'd13:   atan_rom = 24'sd326;
      5'd14:   atan_rom = 24'sd163;
      5'd15:   atan_rom = 24'sd81;
      default: atan_rom = 24'sd0;
    endcase
  endfunction

  // 1/K ~= 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-13 - 2^-14 + 2^-16, as {subtract, shift}
  function automatic logic [5:0] gain_term(input logic [4:0] k);
    case (k)
      5'd0:    gain_term = {1'b0, 5'd1};
      5'd1:    gain_term = {1'b0, 5'd3};
      5'd2:    gain_term = {1'b1, 5'd6};
      5'd3:    gain_term = {1'b1, 5'd9};
      5'd4:    gain_term = {1'b1, 5'd13};
      5'd5:    gain_term = {1'b1, 5'd14};
      5'd6:    gain_term = {1'b0, 5'd16};
      default: gain_term = {1'b0, 5'd31};
    endcase
  endfunction

  function automatic logic signed [15:0] rnd_sat(input logic signed [W-1:0] v);
    logic signed [W-1:0] r;
    r = (v + RHALF) >>> F;
    if (r > SMAX)      rnd_sat = 16'sh7fff;
    else if (r < SMIN) rnd_sat = 16'sh8000;
    else               rnd_sat = 16'(r);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    it_d    = it_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    ax_d    = ax_q;
    ay_d    = ay_q;
    mode_d  = mode_q;
    zvec_d  = zvec_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    zo_d    = zo_q;
    mo_d    = mo_q;
    rdy_d   = 1'b0;
    xs      = x_q >>> it_q;
    ys      = y_q >>> it_q;
    at      = atan_rom(it_q);
    gt      = gain_term(it_q);
    gx      = x_q >>> gt[4:0];
    gy      = y_q >>> gt[4:0];
    // rotation drives z toward 0, vectoring drives y toward 0
    ccw     = mode_q ? ~z_q[23] : y_q[W-1];

    if (io.load) begin
      state_d = S_PRE;
      cnt_d   = '0;
      it_d    = '0;
      x_d     = {{(W-16-F){io.xi[15]}}, io.xi, {F{1'b0}}};
      y_d     = {{(W-16-F){io.yi[15]}}, io.yi, {F{1'b0}}};
      z_d     = {io.zi, 8'h00};
      mode_d  = io.mi;
      // a zero vector has no angle; freeze z so zo returns zi
      zvec_d  = !io.mi && (io.xi == 16'sd0) && (io.yi == 16'sd0);
    end else begin
      if (state_q != S_IDLE) cnt_d = cnt_q + 6'd1;
      case (state_q)
        S_PRE: begin
          if (mode_q) begin
            if (z_q > Q90) begin
              x_d = -y_q; y_d = x_q;  z_d = z_q - Q90;
            end else if (z_q < -Q90) begin
              x_d = y_q;  y_d = -x_q; z_d = z_q + Q90;
            end
          end else if (x_q[W-1]) begin
            if (!y_q[W-1]) begin
              x_d = y_q;  y_d = -x_q; z_d = z_q + Q90;
            end else begin
              x_d = -y_q; y_d = x_q;  z_d = z_q - Q90;
            end
          end
          state_d = S_ROT;
        end
        S_ROT: begin
          if (ccw) begin
            x_d = x_q - ys;
            y_d = y_q + xs;
            if (!zvec_q) z_d = z_q - at;
          end else begin
            x_d = x_q + ys;
            y_d = y_q - xs;
            if (!zvec_q) z_d = z_q + at;
          end
          it_d = it_q + 5'd1;
          if (it_q == 5'(ITER - 1)) begin
            it_d    = '0;
            state_d = S_GAIN;
          end
        end
        S_GAIN: begin
          if (it_q == 5'd0) begin
            ax_d = gx;
            ay_d = gy;
          end else if (gt[5]) begin
            ax_d = ax_q - gx;
            ay_d = ay_q - gy;
          end else begin
            ax_d = ax_q + gx;
            ay_d = ay_q + gy;
          end
          it_d = it_q + 5'd1;
          if (it_q == 5'(NGAIN - 1)) state_d = S_HOLD;
        end
        S_HOLD: begin
          if (cnt_q == LAST) begin
            xo_d    = rnd_sat(ax_q);
            yo_d    = rnd_sat(ay_q);
            zo_d    = 16'((z_q + 24'sd128) >>> 8);
            mo_d    = mode_q;
            rdy_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      it_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      ax_q    <= '0;
      ay_q    <= '0;
      mode_q  <= 1'b0;
      zvec_q  <= 1'b0;
      xo_q    <= '0;
      yo_q    <= '0;
      zo_q    <= '0;
      mo_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      it_q    <= it_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      mode_q  <= mode_d;
      zvec_q  <= zvec_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      zo_q    <= zo_d;
      mo_q    <= mo_d;
      rdy_q   <= rdy_d;
    end
  end

  assign io.xo  = xo_q;
  assign io.yo  = yo_q;
  assign io.zo  = zo_q;
  assign io.mo  = mo_q;
  assign io.rdy = rdy_q;
endmodule

// File: tb/tb_cordic16_serial.sv
// Bench for cordic16_serial: constant vector table, hand-written timing corner
// sequences, sweeps and random operands checked against a real-arithmetic model.
module tb_cordic16_serial;
  logic clk = 1'b0;
  logic rst;
  cordic16_serial_if ifc();
  cordic16_serial #(.ITER(16), .FRAME(40)) dut (.clk(clk), .rst(rst), .io(ifc));

  always #5 clk = ~clk;

  localparam real PI = 3.14159265358979;

  typedef struct {
    int xi, yi, zi;
    bit mi;
    int ex, ey, ez, tx, tz;
  } vec_t;

  vec_t tbl[$];
  int   n_pass = 0, n_total = 0;
  int   ox, oy, oz, ex, ey, ez, xv, yv, zv, mag, ph, amp;
  logic om, tok;
  bit   mv;
  real  th;
  int   amps[3];

  function automatic int rnd(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else          return -$rtoi(0.5 - v);
  endfunction

  function automatic int sat16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int wrap16(input int v);
    return (((v % 65536) + 65536 + 32768) % 65536) - 32768;
  endfunction

  // Ideal results from the mathematical definition of each mode.
  function automatic void model(input int x, input int y, input int z, input bit m,
                                output int rx, output int ry, output int rz);
    real a, fx, fy;
    if (m) begin
      a  = real'(z) * 2.0 * PI / 65536.0;
      fx = real'(x) * $cos(a) - real'(y) * $sin(a);
      fy = real'(x) * $sin(a) + real'(y) * $cos(a);
      rx = sat16(rnd(fx));
      ry = sat16(rnd(fy));
      rz = 0;
    end else begin
      rx = sat16(rnd($sqrt(real'(x) * real'(x) + real'(y) * real'(y))));
      ry = 0;
      if (x == 0 && y == 0) rz = z;
      else rz = wrap16(z + rnd($atan2(real'(y), real'(x)) * 32768.0 / PI));
    end
  endfunction

  task automatic chk(input string nm, input int act, input int exp, input int tol);
    n_total++;
    if (act >= exp - tol && act <= exp + tol) n_pass++;
    else $display("FAIL %s: got %0d, want %0d +/- %0d", nm, act, exp, tol);
  endtask

  task automatic chka(input string nm, input int act, input int exp, input int tol);
    int d;
    d = wrap16(act - exp);
    n_total++;
    if (d >= -tol && d <= tol) n_pass++;
    else $display("FAIL %s: got angle %0d, want %0d +/- %0d", nm, act, exp, tol);
  endtask

  task automatic drive(input int x, input int y, input int z, input bit m);
    ifc.xi = 16'(x); ifc.yi = 16'(y); ifc.zi = 16'(z); ifc.mi = m; ifc.load = 1'b1;
  endtask

  // Load at edge L, expect rdy only in the L+39..L+40 cycle, return results.
  task automatic run_op(input int x, input int y, input int z, input bit m,
                        output int rx, output int ry, output int rz,
                        output logic rm, output logic ok);
    ok = 1'b1;
    @(negedge clk);
    drive(x, y, z, m);
    @(posedge clk); #1 ifc.load = 1'b0;
    for (int k = 1; k <= 38; k++) begin
      @(posedge clk); #1;
      if (ifc.rdy !== 1'b0) ok = 1'b0;
    end
    @(posedge clk); #1;
    if (ifc.rdy !== 1'b1) ok = 1'b0;
    rx = int'(ifc.xo); ry = int'(ifc.yo); rz = int'(ifc.zo); rm = ifc.mo;
    @(posedge clk); #1;
    if (ifc.rdy !== 1'b0) ok = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ifc.load = 1'b0; ifc.xi = '0; ifc.yi = '0; ifc.zi = '0; ifc.mi = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset xo", int'(ifc.xo), 0, 0);
    chk("reset yo", int'(ifc.yo), 0, 0);
    chk("reset zo", int'(ifc.zo), 0, 0);
    chk("reset mo", int'(ifc.mo), 0, 0);
    chk("reset rdy", int'(ifc.rdy), 0, 0);
    @(negedge clk) rst = 1'b0;
    tok = 1'b1;
    repeat (50) begin @(posedge clk); #1; if (ifc.rdy !== 1'b0) tok = 1'b0; end
    chk("no rdy without load", int'(tok), 1, 0);

    // {xi, yi, zi, mi, xo, yo, zo, tol_xy, tol_z}
    tbl.push_back('{16384, 16384, 0, 1'b0, 23170, 0, 8192, 2, 4});
    tbl.push_back('{-16384, 16384, 0, 1'b0, 23170, 0, 24576, 2, 4});
    tbl.push_back('{-16384, -16384, 0, 1'b0, 23170, 0, -24576, 2, 4});
    tbl.push_back('{16384, -16384, 0, 1'b0, 23170, 0, -8192, 2, 4});
    tbl.push_back('{0, 0, 0, 1'b0, 0, 0, 0, 2, 4});
    tbl.push_back('{0, 0, 12345, 1'b0, 0, 0, 12345, 2, 4});
    tbl.push_back('{2929, 2929, 0, 1'b0, 4142, 0, 8192, 2, 4});
    tbl.push_back('{10000, 10000, 0, 1'b0, 14142, 0, 8192, 2, 4});
    tbl.push_back('{20000, 20000, 0, 1'b0, 28284, 0, 8192, 2, 4});
    tbl.push_back('{28284, 0, 0, 1'b0, 28284, 0, 0, 2, 4});
    tbl.push_back('{16384, 16384, 16384, 1'b0, 23170, 0, 24576, 2, 4});
    tbl.push_back('{-16384, 16384, 16384, 1'b0, 23170, 0, -24576, 2, 4});
    tbl.push_back('{32767, 32767, 0, 1'b0, 32767, 0, 8192, 0, 4});
    tbl.push_back('{-32768, -32768, 0, 1'b0, 32767, 0, -24576, 0, 4});
    tbl.push_back('{10000, 10000, 16384, 1'b1, -10000, 10000, 0, 2, 4});
    tbl.push_back('{0, 14142, -32768, 1'b1, 0, -14142, 0, 2, 4});
    for (int i = 0; i < tbl.size(); i++) begin
      run_op(tbl[i].xi, tbl[i].yi, tbl[i].zi, tbl[i].mi, ox, oy, oz, om, tok);
      chk($sformatf("vec%0d xo", i), ox, tbl[i].ex, tbl[i].tx);
      chk($sformatf("vec%0d yo", i), oy, tbl[i].ey, 2);
      chka($sformatf("vec%0d zo", i), oz, tbl[i].ez, tbl[i].tz);
      chk($sformatf("vec%0d mo", i), int'(om), int'(tbl[i].mi), 0);
      chk($sformatf("vec%0d rdy timing", i), int'(tok), 1, 0);
    end

    // Result taken at L+40 while the next load lands on that same edge.
    @(negedge clk); drive(16384, 16384, 0, 1'b0);
    @(posedge clk); #1 ifc.load = 1'b0;
    tok = 1'b1;
    repeat (38) begin @(posedge clk); #1; if (ifc.rdy !== 1'b0) tok = 1'b0; end
    @(posedge clk); #1;
    chk("b2b rdy1", int'(ifc.rdy), 1, 0);
    chk("b2b xo1", int'(ifc.xo), 23170, 2);
    chka("b2b zo1", int'(ifc.zo), 8192, 4);
    drive(-16384, 16384, 0, 1'b0);
    @(posedge clk); #1 ifc.load = 1'b0;
    chk("b2b rdy drop", int'(ifc.rdy), 0, 0);
    chk("b2b xo held", int'(ifc.xo), 23170, 2);
    repeat (38) begin @(posedge clk); #1; if (ifc.rdy !== 1'b0) tok = 1'b0; end
    @(posedge clk); #1;
    chk("b2b rdy2", int'(ifc.rdy), 1, 0);
    chka("b2b zo2", int'(ifc.zo), 24576, 4);
    chk("b2b quiet", int'(tok), 1, 0);
    @(posedge clk);

    // Load while busy: first operation is abandoned without a strobe.
    @(negedge clk); drive(10000, 10000, 16384, 1'b1);
    @(posedge clk); #1 ifc.load = 1'b0;
    tok = 1'b1;
    repeat (19) begin @(posedge clk); #1; if (ifc.rdy !== 1'b0) tok = 1'b0; end
    @(negedge clk); drive(0, 14142, 0, 1'b0);
    @(posedge clk); #1 ifc.load = 1'b0;
    repeat (38) begin @(posedge clk); #1; if (ifc.rdy !== 1'b0) tok = 1'b0; end
    @(posedge clk); #1;
    chk("abort quiet", int'(tok), 1, 0);
    chk("abort rdy", int'(ifc.rdy), 1, 0);
    chk("abort xo", int'(ifc.xo), 14142, 2);
    chka("abort zo", int'(ifc.zo), 16384, 4);
    chk("abort mo", int'(ifc.mo), 0, 0);
    @(posedge clk);

    // load held high for three edges: only the last operands count.
    @(negedge clk); drive(5000, 0, 0, 1'b1);
    @(negedge clk); drive(0, 5000, 0, 1'b0);
    @(negedge clk); drive(28284, 0, 0, 1'b0);
    @(posedge clk); #1 ifc.load = 1'b0;
    tok = 1'b1;
    repeat (38) begin @(posedge clk); #1; if (ifc.rdy !== 1'b0) tok = 1'b0; end
    @(posedge clk); #1;
    chk("hold-load quiet", int'(tok), 1, 0);
    chk("hold-load rdy", int'(ifc.rdy), 1, 0);
    chk("hold-load xo", int'(ifc.xo), 28284, 2);
    chka("hold-load zo", int'(ifc.zo), 0, 4);
    @(posedge clk);

    // Asynchronous reset in mid-frame.
    @(negedge clk); drive(10000, 10000, 8192, 1'b1);
    @(posedge clk); #1 ifc.load = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst xo", int'(ifc.xo), 0, 0);
    chk("midrst yo", int'(ifc.yo), 0, 0);
    chk("midrst zo", int'(ifc.zo), 0, 0);
    chk("midrst mo", int'(ifc.mo), 0, 0);
    chk("midrst rdy", int'(ifc.rdy), 0, 0);
    @(negedge clk) rst = 1'b0;
    tok = 1'b1;
    repeat (50) begin @(posedge clk); #1; if (ifc.rdy !== 1'b0) tok = 1'b0; end
    chk("midrst no rdy", int'(tok), 1, 0);

    // Angle sweep at three levels, 45 degree steps.
    amps[0] = 14142; amps[1] = 1414; amps[2] = 141;
    for (int a = 0; a < 3; a++) begin
      for (int k = 0; k <= 8; k++) begin
        th = real'(k) * PI / 4.0;
        xv = rnd(real'(amps[a]) * $cos(th));
        yv = rnd(real'(amps[a]) * $sin(th));
        run_op(xv, yv, 0, 1'b0, ox, oy, oz, om, tok);
        chk($sformatf("asweep%0d_%0d mag", a, k), ox,
            rnd($sqrt(real'(xv) * xv + real'(yv) * yv)), 2);
        chka($sformatf("asweep%0d_%0d ang", a, k), oz, wrap16(k * 8192),
             (amps[a] < 1000) ? 91 : 4);
      end
    end

    // Rotation sweeps: 129 frames of zi, full and low level.
    for (int s = 0; s < 2; s++) begin
      amp = (s == 0) ? 20000 : 200;
      for (int f = 0; f < 129; f++) begin
        zv = wrap16(-31744 + f * 512);
        run_op(amp, amp, zv, 1'b1, ox, oy, oz, om, tok);
        mag = rnd($sqrt(real'(ox) * ox + real'(oy) * oy));
        ph  = rnd($atan2(real'(oy), real'(ox)) * 32768.0 / PI);
        chk($sformatf("rsweep%0d_%0d mag", s, f), mag, (s == 0) ? 28284 : 283,
            (s == 0) ? 3 : 2);
        chka($sformatf("rsweep%0d_%0d phase", s, f), ph, wrap16(8192 + zv),
             (s == 0) ? 4 : 91);
        chk($sformatf("rsweep%0d_%0d mo", s, f), int'(om), 1, 0);
        chk($sformatf("rsweep%0d_%0d rdy timing", s, f), int'(tok), 1, 0);
      end
    end

    // Random operands against the model.
    for (int r = 0; r < 60; r++) begin
      xv = int'($urandom_range(46000)) - 23000;
      yv = int'($urandom_range(46000)) - 23000;
      if (xv > -2000 && xv < 2000 && yv > -2000 && yv < 2000) xv = 5000;
      zv = int'($urandom_range(65535)) - 32768;
      mv = 1'($urandom_range(1));
      model(xv, yv, zv, mv, ex, ey, ez);
      run_op(xv, yv, zv, mv, ox, oy, oz, om, tok);
      chk($sformatf("rand%0d xo", r), ox, ex, 2);
      chk($sformatf("rand%0d yo", r), oy, ey, 2);
      chka($sformatf("rand%0d zo", r), oz, ez, 4);
      chk($sformatf("rand%0d mo", r), int'(om), int'(mv), 0);
      chk($sformatf("rand%0d rdy timing", r), int'(tok), 1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
